// File: rtl/dmem_arbiter_if.sv
// Single requester port of the data-memory arbiter.
// master = requester side, slave = arbiter side.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between core (c) and DMA/debug (d) masters.
// Define DMEM_ARB_RR_EN for round-robin contention instead of fixed priority.
module dmem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 3,
    parameter int MAX_LOCK     = 4
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave c,
    dmem_arbiter_if.slave d,
    input  logic          d_lock,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wd,
    input  logic [DW-1:0] m_rd
);
    typedef enum logic {ARB, LOCK} state_t;

    localparam int LW = $clog2(MAX_LOCK + 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(MAX_LOCK - 1);

    state_t        state, state_nxt;
    logic [LW-1:0] lock_cnt;
    logic          force_c;
    logic          c_win;
    logic          lock_end;
    logic          c_gnt, d_gnt;
    logic          c_rvalid, d_rvalid;
    logic [DW-1:0] c_rdata, d_rdata;

`ifdef DMEM_ARB_RR_EN
    logic last_d;

    always_ff @(posedge clk) begin
        if (rst)        last_d <= 1'b1;
        else if (c_gnt) last_d <= 1'b0;
        else if (d_gnt) last_d <= 1'b1;
    end

    assign c_win = force_c | last_d;
`else
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (rst || !d.req || d_gnt)
            starve_cnt <= '0;
        else if (state == ARB && starve_cnt != STARVE_MAX)
            starve_cnt <= starve_cnt + 1'b1;
    end

    assign c_win = force_c | (starve_cnt != STARVE_MAX);
`endif

    // High when lock_cnt reaches MAX_LOCK at the edge ending this cycle
    assign lock_end = (state == LOCK) ? (lock_cnt == LOCK_LAST)
                                      : (MAX_LOCK == 1);

    always_ff @(posedge clk) begin
        if (rst) state <= ARB;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ARB:  if (d_gnt && d_lock && !lock_end) state_nxt = LOCK;
            LOCK: if (!d_lock || lock_end)          state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_comb begin
        c_gnt  = 1'b0;
        d_gnt  = 1'b0;
        m_we   = 1'b0;
        m_addr = '0;
        m_wd   = '0;
        if (!rst) begin
            unique case (state)
                ARB: begin
                    c_gnt = c.req & (~d.req | c_win);
                    d_gnt = d.req & ~c_gnt;
                end
                LOCK:    d_gnt = d.req;
                default: ;
            endcase
        end
        if (c_gnt) begin
            m_we   = c.we;
            m_addr = c.addr;
            m_wd   = c.wdata;
        end else if (d_gnt) begin
            m_we   = d.we;
            m_addr = d.addr;
            m_wd   = d.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state_nxt != LOCK)
            lock_cnt <= '0;
        else if (state == LOCK)
            lock_cnt <= lock_cnt + 1'b1;
        else
            lock_cnt <= LW'(1);
    end

    // A burst cut short by the counter hands the next contention to C
    always_ff @(posedge clk) begin
        if (rst)
            force_c <= 1'b0;
        else if (lock_end && (state == LOCK || (d_gnt && d_lock)))
            force_c <= 1'b1;
        else if (state == ARB && c.req && d.req)
            force_c <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            c_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            c_rvalid <= c_gnt & ~c.we;
            d_rvalid <= d_gnt & ~d.we;
            if (c_gnt && !c.we) c_rdata <= m_rd;
            if (d_gnt && !d.we) d_rdata <= m_rd;
        end
    end

    assign c.gnt    = c_gnt;
    assign d.gnt    = d_gnt;
    assign c.rvalid = c_rvalid;
    assign d.rvalid = d_rvalid;
    assign c.rdata  = c_rdata;
    assign d.rdata  = d_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed memory model.
// Honours DMEM_ARB_RR_EN for the contention-pattern expectations.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        d_lock;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wd;
    logic [31:0] m_rd;
    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    dmem_arbiter_if #(.AW(32), .DW(32)) c_if ();
    dmem_arbiter_if #(.AW(32), .DW(32)) d_if ();

    dmem_arbiter #(
        .AW(32), .DW(32), .STARVE_LIMIT(3), .MAX_LOCK(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .c      (c_if.slave),
        .d      (d_if.slave),
        .d_lock (d_lock),
        .m_we   (m_we),
        .m_addr (m_addr),
        .m_wd   (m_wd),
        .m_rd   (m_rd)
    );

    always #5 clk = ~clk;

    assign m_rd = mem[m_addr[9:2]];
    always @(posedge clk) if (m_we) mem[m_addr[9:2]] <= m_wd;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv_c(input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] wd);
        c_if.req = r; c_if.we = w; c_if.addr = a; c_if.wdata = wd;
    endtask

    task automatic drv_d(input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic l);
        d_if.req = r; d_if.we = w; d_if.addr = a; d_if.wdata = wd;
        d_lock = l;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic exp_c;
    logic prev_d;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst = 1'b1;
        drv_c(1'b1, 1'b1, 32'h40, 32'hBAD0BAD0);
        drv_d(1'b1, 1'b1, 32'h44, 32'h0BAD0BAD, 1'b1);
        next_cyc();
        mid();
        chk("rst_c_gnt", {31'b0, c_if.gnt}, 32'd0);
        chk("rst_d_gnt", {31'b0, d_if.gnt}, 32'd0);
        chk("rst_m_we", {31'b0, m_we}, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_c_rvalid", {31'b0, c_if.rvalid}, 32'd0);
        chk("rst_d_rvalid", {31'b0, d_if.rvalid}, 32'd0);
        chk("rst_c_rdata", c_if.rdata, 32'd0);
        chk("rst_d_rdata", d_if.rdata, 32'd0);

        // core write then back-to-back reads
        next_cyc();
        rst = 1'b0;
        drv_c(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        drv_d(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        mid();
        chk("t1_wr_c_gnt", {31'b0, c_if.gnt}, 32'd1);
        chk("t1_wr_m_we", {31'b0, m_we}, 32'd1);
        chk("t1_wr_m_addr", m_addr, 32'h10);
        chk("t1_wr_m_wd", m_wd, 32'hDEADBEEF);
        next_cyc();
        drv_c(1'b1, 1'b0, 32'h10, 32'h0);
        mid();
        chk("t1_rd_c_gnt", {31'b0, c_if.gnt}, 32'd1);
        chk("t1_rd_m_we", {31'b0, m_we}, 32'd0);
        chk("t1_wr_no_rvalid", {31'b0, c_if.rvalid}, 32'd0);
        next_cyc();
        drv_c(1'b1, 1'b0, 32'h40, 32'h0);
        mid();
        chk("t1_rvalid", {31'b0, c_if.rvalid}, 32'd1);
        chk("t1_rdata", c_if.rdata, 32'hDEADBEEF);
        next_cyc();
        drv_c(1'b0, 1'b0, 32'h0, 32'h0);
        mid();
        chk("rst_no_write_rvalid", {31'b0, c_if.rvalid}, 32'd1);
        chk("rst_no_write_rdata", c_if.rdata, 32'd0);
        chk("idle_m_addr", m_addr, 32'd0);
        chk("idle_m_wd", m_wd, 32'd0);
        next_cyc();
        mid();
        chk("rvalid_one_cycle", {31'b0, c_if.rvalid}, 32'd0);
        chk("rdata_hold", c_if.rdata, 32'd0);

        // contention pattern from a fresh reset
        next_cyc();
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        drv_c(1'b1, 1'b0, 32'h10, 32'h0);
        drv_d(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        prev_d = 1'b0;
        for (int i = 0; i < 8; i++) begin
`ifdef DMEM_ARB_RR_EN
            exp_c = (i % 2) == 0;
`else
            exp_c = (i % 4) != 3;
`endif
            mid();
            chk($sformatf("t2_c_gnt_%0d", i), {31'b0, c_if.gnt},
                {31'b0, exp_c});
            chk($sformatf("t2_d_gnt_%0d", i), {31'b0, d_if.gnt},
                {31'b0, ~exp_c});
            chk($sformatf("t2_d_rvalid_%0d", i), {31'b0, d_if.rvalid},
                {31'b0, prev_d});
            prev_d = ~exp_c;
            next_cyc();
        end
        drv_c(1'b0, 1'b0, 32'h0, 32'h0);
        drv_d(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        next_cyc();

        // DMA write followed by core read of the same word
        drv_d(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0);
        mid();
        chk("t6_d_gnt", {31'b0, d_if.gnt}, 32'd1);
        chk("t6_m_we", {31'b0, m_we}, 32'd1);
        next_cyc();
        drv_d(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drv_c(1'b1, 1'b0, 32'h20, 32'h0);
        mid();
        chk("t6_c_gnt", {31'b0, c_if.gnt}, 32'd1);
        next_cyc();
        drv_c(1'b0, 1'b0, 32'h0, 32'h0);
        mid();
        chk("t6_c_rvalid", {31'b0, c_if.rvalid}, 32'd1);
        chk("t6_c_rdata", c_if.rdata, 32'h12345678);
        next_cyc();

        // bounded lock burst: 4 D grants then C
        drv_d(1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
        mid();
        chk("t3_d_gnt_0", {31'b0, d_if.gnt}, 32'd1);
        next_cyc();
        drv_c(1'b1, 1'b0, 32'h10, 32'h0);
        for (int i = 1; i < 4; i++) begin
            mid();
            chk($sformatf("t3_d_gnt_%0d", i), {31'b0, d_if.gnt}, 32'd1);
            chk($sformatf("t3_c_blk_%0d", i), {31'b0, c_if.gnt}, 32'd0);
            chk($sformatf("t3_d_rdata_%0d", i), d_if.rdata, 32'h12345678);
            next_cyc();
        end
        mid();
        chk("t3_c_gnt_4", {31'b0, c_if.gnt}, 32'd1);
        chk("t3_d_gnt_4", {31'b0, d_if.gnt}, 32'd0);
        chk("t3_d_rvalid_4", {31'b0, d_if.rvalid}, 32'd1);
        next_cyc();
        drv_c(1'b0, 1'b0, 32'h0, 32'h0);
        drv_d(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        next_cyc();

        // reset in the second LOCK cycle
        drv_d(1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
        mid();
        chk("t4_enter_d_gnt", {31'b0, d_if.gnt}, 32'd1);
        next_cyc();
        mid();
        chk("t4_lock1_d_gnt", {31'b0, d_if.gnt}, 32'd1);
        next_cyc();
        rst = 1'b1;
        drv_d(1'b1, 1'b1, 32'h30, 32'h00000055, 1'b1);
        mid();
        chk("t4_rst_d_gnt", {31'b0, d_if.gnt}, 32'd0);
        chk("t4_rst_m_we", {31'b0, m_we}, 32'd0);
        next_cyc();
        rst = 1'b0;
        drv_d(1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
        drv_c(1'b1, 1'b0, 32'h30, 32'h0);
        mid();
        chk("t4_d_rvalid", {31'b0, d_if.rvalid}, 32'd0);
        chk("t4_c_first", {31'b0, c_if.gnt}, 32'd1);
        chk("t4_d_lose", {31'b0, d_if.gnt}, 32'd0);
        next_cyc();
        drv_c(1'b0, 1'b0, 32'h0, 32'h0);
        drv_d(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        mid();
        chk("t4_c_rvalid", {31'b0, c_if.rvalid}, 32'd1);
        chk("t4_no_rst_write", c_if.rdata, 32'd0);
        next_cyc();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
